// File: rtl/main_memory_responder.sv
// Main-memory responder: queues block-fill requests, returns each block after a
// fixed latency, and absorbs evicted-block writebacks into a block-array store.
module main_memory_responder #(
  parameter int unsigned CACHE_BLOCK_SIZE  = 128,
  parameter int unsigned BLOCK_OFFSET_BITS = 2,
  parameter int unsigned MEM_BLOCKS        = 1024,
  parameter int unsigned READ_LATENCY      = 10,
  parameter int unsigned REQ_QUEUE_DEPTH   = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_vld_i,
  input  logic [31:0]                 req_addr_i,
  output logic                        req_rdy_o,
  output logic                        resp_vld_o,
  output logic [CACHE_BLOCK_SIZE-1:0] resp_data_o,
  input  logic                        wb_vld_i,
  input  logic [31:0]                 wb_addr_i,
  input  logic [CACHE_BLOCK_SIZE-1:0] wb_data_i,
  output logic                        err_overflow_o
);

  localparam int unsigned IDX_LSB = BLOCK_OFFSET_BITS + 2;
  localparam int unsigned IW      = $clog2(MEM_BLOCKS);
  localparam int unsigned PW      = $clog2(REQ_QUEUE_DEPTH) + 1;
  localparam int unsigned QAW     = (REQ_QUEUE_DEPTH > 1) ? $clog2(REQ_QUEUE_DEPTH) : 1;
  localparam int unsigned CW      = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESPOND} state_t;

  state_t                      state, state_nxt;
  logic [CW-1:0]               cnt, cnt_nxt;
  logic [IW-1:0]               cur_idx, idx_nxt;
  logic [PW-1:0]               wptr, rptr;
  logic [IW-1:0]               queue [REQ_QUEUE_DEPTH];
  logic [CACHE_BLOCK_SIZE-1:0] mem   [MEM_BLOCKS];

  logic [IW-1:0]               req_idx, wb_idx;
  logic [QAW-1:0]              wslot, rslot;
  logic                        fifo_full, fifo_empty;
  logic                        accept, push, pop, load;
  logic [CACHE_BLOCK_SIZE-1:0] load_data;
  logic                        unused_addr_bits;

  // Block index extraction; addresses alias modulo the store size
  assign req_idx = req_addr_i[IDX_LSB +: IW];
  assign wb_idx  = wb_addr_i[IDX_LSB +: IW];
  assign unused_addr_bits = ^{req_addr_i[31:IDX_LSB+IW], req_addr_i[IDX_LSB-1:0],
                              wb_addr_i[31:IDX_LSB+IW],  wb_addr_i[IDX_LSB-1:0]};

  // Queue status from registered pointers (extra MSB distinguishes full from empty)
  assign wslot      = (REQ_QUEUE_DEPTH > 1) ? wptr[QAW-1:0] : '0;
  assign rslot      = (REQ_QUEUE_DEPTH > 1) ? rptr[QAW-1:0] : '0;
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (PW'(wptr - rptr) == PW'(REQ_QUEUE_DEPTH));
  assign req_rdy_o  = !rst_i && !fifo_full;
  assign accept     = req_vld_i && req_rdy_o;
  // A request arriving into an idle, empty responder bypasses the queue
  assign push       = accept && !((state == ST_IDLE) && fifo_empty);

  // Write-before-read: a same-cycle writeback to the block being loaded wins
  assign load_data = (wb_vld_i && (wb_idx == cur_idx)) ? wb_data_i : mem[cur_idx];

  // Next-state, counter and service-index logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = cur_idx;
    pop       = 1'b0;
    load      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          idx_nxt   = queue[rslot];
          pop       = 1'b1;
          cnt_nxt   = CW'(READ_LATENCY - 2);
          state_nxt = ST_WAIT;
        end else if (accept) begin
          idx_nxt   = req_idx;
          cnt_nxt   = CW'(READ_LATENCY - 2);
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          load      = 1'b1;
          state_nxt = ST_RESPOND;
        end else begin
          cnt_nxt = CW'(cnt - 1'b1);
        end
      end
      ST_RESPOND: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Control state, queue pointers and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      cur_idx        <= '0;
      wptr           <= '0;
      rptr           <= '0;
      resp_vld_o     <= 1'b0;
      resp_data_o    <= '0;
      err_overflow_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cur_idx    <= idx_nxt;
      resp_vld_o <= load;
      if (push)                   wptr           <= PW'(wptr + 1'b1);
      if (pop)                    rptr           <= PW'(rptr + 1'b1);
      if (load)                   resp_data_o    <= load_data;
      if (req_vld_i && !req_rdy_o) err_overflow_o <= 1'b1;
    end
  end

  // Queue storage holds block indices of pending requests
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) queue[wslot] <= req_idx;
  end

  // Backing store; contents survive reset
  always_ff @(posedge clk_i) begin
    if (!rst_i && wb_vld_i) mem[wb_idx] <= wb_data_i;
  end

endmodule
